// File: rtl/spi_sample_scheduler.sv
// Periodic sample scheduler for an SPI master: issues conversion requests at a fixed rate,
// captures returned words into a small FIFO and reports missed ticks, overruns and timeouts.
module spi_sample_scheduler #(
  parameter int unsigned MAX_DATA_LENGTH = 16,
  parameter int unsigned NUM_DEVICES     = 1,
  parameter int unsigned SAMPLE_PERIOD   = 1000,
  parameter int unsigned NUM_DATA        = 16,
  parameter int unsigned STARTUP_CLOCKS  = 8,
  parameter int unsigned TIMEOUT_CLOCKS  = 4096,
  parameter int unsigned FIFO_DEPTH      = 8,
  localparam int unsigned W  = MAX_DATA_LENGTH * NUM_DEVICES,
  localparam int unsigned NL = $clog2(MAX_DATA_LENGTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic [W-1:0]  tx_word_i,
  output logic          spi_request_o,
  output logic [NL-1:0] spi_num_data_o,
  output logic [W-1:0]  spi_data_o,
  input  logic [W-1:0]  spi_data_i,
  input  logic          spi_data_valid_i,
  output logic [W-1:0]  sample_data_o,
  output logic          sample_valid_o,
  input  logic          sample_ready_i,
  output logic          missed_tick_o,
  output logic          overrun_o,
  output logic          timeout_o,
  output logic [7:0]    drop_count_o
);

  localparam int unsigned PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned SW   = $clog2(STARTUP_CLOCKS + 1);
  localparam int unsigned TW   = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTRW = AW + 1;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_REQUEST,
    ST_BUSY
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   tick_cnt;
  logic [SW-1:0]   su_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            tick;
  logic            push, tmo_event, missed_event, load_tx;

  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [PTRW-1:0] wptr, rptr, wptr_d, rptr_d;
  logic            full, empty, pop, wr, drop;

  assign spi_num_data_o = NL'(NUM_DATA);

  // Sample-rate tick: free-running while enabled, held at zero otherwise
  assign tick = enable_i && (tick_cnt == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || tick) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_STARTUP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    tmo_event    = 1'b0;
    missed_event = 1'b0;
    load_tx      = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        if (su_cnt == SW'(STARTUP_CLOCKS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (tick) begin
          load_tx = 1'b1;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        missed_event = tick;
        state_d      = ST_BUSY;
      end
      ST_BUSY: begin
        missed_event = tick;
        if (spi_data_valid_i) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT_CLOCKS - 1)) begin
          tmo_event = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // Startup/timeout counters, request strobe and transmit word register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      su_cnt        <= '0;
      tmo_cnt       <= '0;
      spi_request_o <= 1'b0;
      spi_data_o    <= '0;
    end else begin
      if (state_q == ST_STARTUP) su_cnt <= su_cnt + 1'b1;
      if (state_q == ST_REQUEST)   tmo_cnt <= '0;
      else if (state_q == ST_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      spi_request_o <= (state_d == ST_REQUEST);
      if (load_tx) spi_data_o <= tx_word_i;
    end
  end

  // FIFO: a pop frees the slot for a same-cycle push even when full
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = !empty && sample_ready_i;
  assign wr     = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign wptr_d = wptr + PTRW'(wr);
  assign rptr_d = rptr + PTRW'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr           <= '0;
      rptr           <= '0;
      sample_valid_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      wptr           <= wptr_d;
      rptr           <= rptr_d;
      sample_valid_o <= (wptr_d != rptr_d);
      if (wr) mem[wptr[AW-1:0]] <= spi_data_i;
    end
  end

  assign sample_data_o = mem[rptr[AW-1:0]];

  // Sticky status: a same-cycle event takes precedence over clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      missed_tick_o <= 1'b0;
      overrun_o     <= 1'b0;
      timeout_o     <= 1'b0;
      drop_count_o  <= '0;
    end else begin
      missed_tick_o <= (missed_tick_o && !clear_i) || missed_event;
      overrun_o     <= (overrun_o && !clear_i) || drop;
      timeout_o     <= (timeout_o && !clear_i) || tmo_event;
      if (drop) begin
        if (clear_i)                    drop_count_o <= 8'd1;
        else if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
      end else if (clear_i) begin
        drop_count_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Randomized bench for spi_sample_scheduler: behavioural model plus a FIFO scoreboard
// with an independent output monitor.
module tb_spi_sample_scheduler;
  localparam int unsigned W    = 16;
  localparam int unsigned P    = 20;
  localparam int unsigned SC   = 8;
  localparam int unsigned TO   = 64;
  localparam int unsigned D    = 8;
  localparam int unsigned NUMD = 15;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1, enable_i = 1'b0, clear_i = 1'b0;
  logic [W-1:0] tx_word_i = '0, spi_data_i = '0;
  logic         spi_data_valid_i = 1'b0, sample_ready_i = 1'b0;
  logic         spi_request_o, sample_valid_o, missed_tick_o, overrun_o, timeout_o;
  logic [3:0]   spi_num_data_o;
  logic [W-1:0] spi_data_o, sample_data_o;
  logic [7:0]   drop_count_o;

  always #5 clk = ~clk;

  spi_sample_scheduler #(
    .MAX_DATA_LENGTH(16), .NUM_DEVICES(1), .SAMPLE_PERIOD(P), .NUM_DATA(NUMD),
    .STARTUP_CLOCKS(SC), .TIMEOUT_CLOCKS(TO), .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .tx_word_i(tx_word_i), .spi_request_o(spi_request_o), .spi_num_data_o(spi_num_data_o),
    .spi_data_o(spi_data_o), .spi_data_i(spi_data_i), .spi_data_valid_i(spi_data_valid_i),
    .sample_data_o(sample_data_o), .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i), .missed_tick_o(missed_tick_o), .overrun_o(overrun_o),
    .timeout_o(timeout_o), .drop_count_o(drop_count_o)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: values the DUT outputs should show in the current cycle
  bit           m_init = 0;
  int           m_cnt, m_su_left, m_wait, m_occ, m_drops;
  bit           m_req, m_inflight, m_missed, m_overrun, m_timeout;
  logic [W-1:0] m_tx;

  // Master model
  bit mst_armed = 0;
  int mst_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input bit y,
                            input logic [W-1:0] tw, input bit v, input logic [W-1:0] d);
    bit tick, push, pop, full;
    if (r) begin
      m_cnt = 0; m_su_left = SC; m_wait = 0; m_occ = 0; m_drops = 0;
      m_req = 0; m_inflight = 0; m_missed = 0; m_overrun = 0; m_timeout = 0;
      m_tx = '0; exp_q.delete(); m_init = 1;
      return;
    end
    tick = e && (m_cnt == P - 1);
    push = 0;
    if (c) begin
      m_missed = 0; m_overrun = 0; m_timeout = 0; m_drops = 0;
    end
    if (m_su_left > 0) begin
      m_su_left--;
    end else if (m_req) begin
      m_req = 0; m_inflight = 1; m_wait = 0;
      if (tick) m_missed = 1;
    end else if (m_inflight) begin
      if (tick) m_missed = 1;
      if (v) begin
        push = 1; m_inflight = 0;
      end else if (m_wait == TO - 1) begin
        m_timeout = 1; m_inflight = 0;
      end else begin
        m_wait++;
      end
    end else if (tick) begin
      m_tx = tw; m_req = 1;
    end
    full = (m_occ == D);
    pop  = (m_occ > 0) && y;
    if (pop) m_occ--;
    if (push) begin
      if (full && !pop) begin
        m_overrun = 1;
        if (m_drops < 255) m_drops++;
      end else begin
        m_occ++;
        exp_q.push_back(d);
      end
    end
    m_cnt = !e ? 0 : ((m_cnt == P - 1) ? 0 : m_cnt + 1);
  endtask

  // lat_mode: >0 fixed latency, 0 never respond, <0 random latency per request
  task automatic run(input int n, input int lat_mode, input int rdy_pct, input int clr_pct,
                     input int rst_pct, input int en_pct, input bit fixed);
    bit r, e, c, y, v;
    logic [W-1:0] tw, d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (m_init) begin
        chk("request",      64'(spi_request_o),  64'(m_req));
        chk("spi_data",     64'(spi_data_o),     64'(m_tx));
        chk("sample_valid", 64'(sample_valid_o), 64'(m_occ > 0));
        chk("missed_tick",  64'(missed_tick_o),  64'(m_missed));
        chk("overrun",      64'(overrun_o),      64'(m_overrun));
        chk("timeout",      64'(timeout_o),      64'(m_timeout));
        chk("drop_count",   64'(drop_count_o),   64'(m_drops));
        chk("num_data",     64'(spi_num_data_o), 64'(NUMD));
      end
      r  = ($urandom_range(99) < rst_pct);
      e  = ($urandom_range(99) < en_pct);
      c  = ($urandom_range(99) < clr_pct);
      y  = !r && ($urandom_range(99) < rdy_pct);
      tw = W'($urandom);
      d  = fixed ? 16'hA5A5 : W'($urandom);
      v  = 0;
      if (r || !m_init) begin
        mst_armed = 0;
      end else begin
        if (mst_cnt > 0) mst_cnt--;
        v = mst_armed && (mst_cnt == 0);
        if (v) mst_armed = 0;
        if (!v && !mst_armed && !m_inflight && ($urandom_range(99) < 3)) v = 1;
        if (m_req) begin
          int l;
          l = (lat_mode < 0) ? int'($urandom_range(70, 1)) : lat_mode;
          if (l > 0) begin
            mst_armed = 1; mst_cnt = l;
          end
        end
      end
      rst_i = r; enable_i = e; clear_i = c; sample_ready_i = y;
      tx_word_i = tw; spi_data_valid_i = v; spi_data_i = d;
      model_step(r, e, c, y, tw, v, d);
    end
  endtask

  // Monitor: every accepted FIFO head must match the next expected sample
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_init && sample_valid_o === 1'b1 && sample_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_pop: got %0h expected no sample at %0t", sample_data_o, $time);
        end else begin
          chk("sample_data", 64'(sample_data_o), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    run(3,    12, 0,   0, 100, 0,   1);  // reset
    run(400,  12, 100, 0, 0,   100, 1);  // nominal rate, fixed word
    run(600,  30, 80,  2, 0,   100, 0);  // slow master: missed ticks, clears
    run(300,  12, 0,   0, 0,   100, 0);  // consumer stalled: fill and overrun
    run(400,  12, 30,  1, 0,   100, 0);  // drain with full-FIFO push/pop overlap
    run(400,  0,  70,  0, 0,   100, 0);  // master silent: timeouts
    run(3000, -1, 60,  3, 1,   95,  0);  // mixed random incl. resets
    run(200,  12, 100, 0, 0,   100, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
